// File: rtl/a2d_rr_seq.sv
// a2d_rr_seq: round-robin conversion sequencer for the A2D path.
// Each request converts one channel (left load, right load, battery) in a fixed
// rotation. Each conversion uses two 16-bit SPI frames. The first frame selects
// the channel and its reply is discarded. The reply to the second frame holds
// the result.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   nxt      in   single-cycle conversion request
//   done     in   SPI master frame-complete pulse
//   rd_data  in   SPI receive word, valid while done=1
//   wrt      out  single-cycle pulse starting an SPI frame
//   cmd      out  SPI transmit word {2'b00, chnl, 11'h000}
//   lft_ld   out  latest left load cell result
//   rght_ld  out  latest right load cell result
//   batt     out  latest battery result
//   lft_vld, rght_vld, batt_vld  out  single-cycle update strobes
//   busy     out  high from request acceptance until result capture
module a2d_rr_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        lft_vld,
  output logic        rght_vld,
  output logic        batt_vld,
  output logic        busy
);

  localparam logic [2:0] LFT_CH  = 3'd0;
  localparam logic [2:0] RGHT_CH = 3'd4;
  localparam logic [2:0] BATT_CH = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD1  = 3'd1,
    WAIT1 = 3'd2,
    GAP   = 3'd3,
    CMD2  = 3'd4,
    WAIT2 = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        pend_q, pend_d;
  logic        wrt_q, wrt_d;
  logic [15:0] cmd_q, cmd_d;
  logic [11:0] lft_q, lft_d;
  logic [11:0] rght_q, rght_d;
  logic [11:0] batt_q, batt_d;
  logic [2:0]  vld_q, vld_d;     // {batt, rght, lft}
  logic        busy_q, busy_d;

  // Map the rotation pointer to the A2D channel address.
  function automatic logic [2:0] chan_of(input logic [1:0] p);
    logic [2:0] c;
    case (p)
      2'd0:    c = LFT_CH;
      2'd1:    c = RGHT_CH;
      2'd2:    c = BATT_CH;
      default: c = LFT_CH;
    endcase
    return c;
  endfunction

  // Advance the pointer 0->1->2->0. The unused encoding 3 recovers to 0.
  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    logic [1:0] n;
    case (p)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // Next-state, pending-request and output-register computation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wrt_d   = 1'b0;
    cmd_d   = cmd_q;
    lft_d   = lft_q;
    rght_d  = rght_q;
    batt_d  = batt_q;
    vld_d   = 3'b000;
    busy_d  = busy_q;

    // A request that arrives while a conversion is in flight is remembered once.
    // This includes a request in the capture cycle.
    if ((state_q != IDLE) && nxt) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    case (state_q)
      IDLE: begin
        if (nxt || pend_q) begin
          state_d = CMD1;
          pend_d  = 1'b0;
          wrt_d   = 1'b1;
          busy_d  = 1'b1;
          cmd_d   = {2'b00, chan_of(ptr_q), 11'h000};
        end else begin
          state_d = IDLE;
        end
      end
      CMD1: begin
        state_d = WAIT1;
      end
      WAIT1: begin
        if (done) begin
          state_d = GAP;
        end else begin
          state_d = WAIT1;
        end
      end
      GAP: begin
        // The idle cycle lets the SPI master release SS_n before the second frame.
        state_d = CMD2;
        wrt_d   = 1'b1;
      end
      CMD2: begin
        state_d = WAIT2;
      end
      WAIT2: begin
        if (done) begin
          case (ptr_q)
            2'd0: begin
              lft_d = rd_data[11:0];
              vld_d = 3'b001;
            end
            2'd1: begin
              rght_d = rd_data[11:0];
              vld_d  = 3'b010;
            end
            2'd2: begin
              batt_d = rd_data[11:0];
              vld_d  = 3'b100;
            end
            default: begin
              vld_d = 3'b000;
            end
          endcase
          ptr_d   = ptr_next(ptr_q);
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = WAIT2;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      pend_q  <= 1'b0;
      wrt_q   <= 1'b0;
      cmd_q   <= 16'h0000;
      lft_q   <= 12'h000;
      rght_q  <= 12'h000;
      batt_q  <= 12'h000;
      vld_q   <= 3'b000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      wrt_q   <= wrt_d;
      cmd_q   <= cmd_d;
      lft_q   <= lft_d;
      rght_q  <= rght_d;
      batt_q  <= batt_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  assign wrt      = wrt_q;
  assign cmd      = cmd_q;
  assign lft_ld   = lft_q;
  assign rght_ld  = rght_q;
  assign batt     = batt_q;
  assign lft_vld  = vld_q[0];
  assign rght_vld = vld_q[1];
  assign batt_vld = vld_q[2];
  assign busy     = busy_q;

endmodule

// File: tb/tb_a2d_rr_seq.sv
// Testbench for a2d_rr_seq: a directed cycle table, a reset/spurious-done
// sequence, and a randomized run against a protocol-level reference model.
module tb_a2d_rr_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nxt = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [11:0] lft_ld, rght_ld, batt;
  logic        lft_vld, rght_vld, batt_vld, busy;

  int errors = 0;
  int checks = 0;

  a2d_rr_seq dut (
    .clk(clk), .rst(rst), .nxt(nxt), .done(done), .rd_data(rd_data),
    .wrt(wrt), .cmd(cmd), .lft_ld(lft_ld), .rght_ld(rght_ld), .batt(batt),
    .lft_vld(lft_vld), .rght_vld(rght_vld), .batt_vld(batt_vld), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        nxt;
    logic        done;
    logic [15:0] rd;
    logic        wrt;
    logic        busy;
    logic [15:0] cmd;
    logic [2:0]  vld;
    logic [11:0] l;
    logic [11:0] r;
    logic [11:0] b;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic n, input logic d, input logic [15:0] rd,
                              input logic w, input logic bz, input logic [15:0] c,
                              input logic [2:0] v, input logic [11:0] l,
                              input logic [11:0] r, input logic [11:0] b);
    vec_t t;
    t.nxt = n; t.done = d; t.rd = rd; t.wrt = w; t.busy = bz; t.cmd = c;
    t.vld = v; t.l = l; t.r = r; t.b = b;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] vld_bus();
    return {batt_vld, rght_vld, lft_vld};
  endfunction

  // reference model state for the randomized phase
  int          chans[3] = '{0, 4, 5};
  int          ptr_m;
  logic [11:0] reg_m[3];
  logic        act, pend_m, restart_now, restart_next, wrt2_now, wrt2_next, outstanding;
  int          frames, done_at;
  logic [15:0] cmd_m;
  logic        n_r, d_r, real_d, exp_wrt;
  logic [2:0]  exp_vld;
  logic [15:0] rd_r;

  initial begin
    // reset state
    step();
    chk("rst_wrt", 32'(wrt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'h0000);
    chk("rst_vld", 32'(vld_bus()), 32'd0);
    chk("rst_lft", 32'(lft_ld), 32'd0);
    rst = 1'b0;

    //   nxt  done rd        wrt  busy cmd       vld     lft      rght     batt
    add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 3'b000, 12'h000, 12'h000, 12'h000);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 3'b000, 12'h000, 12'h000, 12'h000);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 3'b000, 12'h000, 12'h000, 12'h000);
    add(1'b0, 1'b1, 16'hABCD, 1'b0, 1'b1, 16'h0000, 3'b000, 12'h000, 12'h000, 12'h000);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 3'b000, 12'h000, 12'h000, 12'h000);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 3'b000, 12'h000, 12'h000, 12'h000);
    add(1'b0, 1'b1, 16'hF123, 1'b0, 1'b0, 16'h0000, 3'b001, 12'h123, 12'h000, 12'h000);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 3'b000, 12'h123, 12'h000, 12'h000);
    add(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 3'b000, 12'h123, 12'h000, 12'h000);
    add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2000, 3'b000, 12'h123, 12'h000, 12'h000);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, 3'b000, 12'h123, 12'h000, 12'h000);
    add(1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h2000, 3'b000, 12'h123, 12'h000, 12'h000);
    add(1'b1, 1'b1, 16'h1FFF, 1'b1, 1'b1, 16'h2000, 3'b000, 12'h123, 12'h000, 12'h000);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, 3'b000, 12'h123, 12'h000, 12'h000);
    add(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, 3'b000, 12'h123, 12'h000, 12'h000);
    add(1'b0, 1'b1, 16'h0456, 1'b0, 1'b0, 16'h2000, 3'b010, 12'h123, 12'h456, 12'h000);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2800, 3'b000, 12'h123, 12'h456, 12'h000);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2800, 3'b000, 12'h123, 12'h456, 12'h000);
    add(1'b0, 1'b1, 16'h0EEE, 1'b0, 1'b1, 16'h2800, 3'b000, 12'h123, 12'h456, 12'h000);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2800, 3'b000, 12'h123, 12'h456, 12'h000);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2800, 3'b000, 12'h123, 12'h456, 12'h000);
    add(1'b0, 1'b1, 16'h0789, 1'b0, 1'b0, 16'h2800, 3'b100, 12'h123, 12'h456, 12'h789);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h2800, 3'b000, 12'h123, 12'h456, 12'h789);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h2800, 3'b000, 12'h123, 12'h456, 12'h789);
    add(1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 3'b000, 12'h123, 12'h456, 12'h789);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 3'b000, 12'h123, 12'h456, 12'h789);
    add(1'b0, 1'b1, 16'h0111, 1'b0, 1'b1, 16'h0000, 3'b000, 12'h123, 12'h456, 12'h789);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h0000, 3'b000, 12'h123, 12'h456, 12'h789);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0000, 3'b000, 12'h123, 12'h456, 12'h789);
    add(1'b1, 1'b1, 16'h5AAA, 1'b0, 1'b0, 16'h0000, 3'b001, 12'hAAA, 12'h456, 12'h789);
    add(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h2000, 3'b000, 12'hAAA, 12'h456, 12'h789);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2000, 3'b000, 12'hAAA, 12'h456, 12'h789);

    foreach (vecs[i]) begin
      nxt = vecs[i].nxt; done = vecs[i].done; rd_data = vecs[i].rd;
      step();
      chk($sformatf("v%0d_wrt", i), 32'(wrt), 32'(vecs[i].wrt));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d_cmd", i), 32'(cmd), 32'(vecs[i].cmd));
      chk($sformatf("v%0d_vld", i), 32'(vld_bus()), 32'(vecs[i].vld));
      chk($sformatf("v%0d_lft", i), 32'(lft_ld), 32'(vecs[i].l));
      chk($sformatf("v%0d_rght", i), 32'(rght_ld), 32'(vecs[i].r));
      chk($sformatf("v%0d_batt", i), 32'(batt), 32'(vecs[i].b));
    end
    nxt = 1'b0; done = 1'b0;

    // reset asserted in WAIT2, then an in-flight done in IDLE
    done = 1'b1; rd_data = 16'h0333;
    step();
    done = 1'b0;
    step();
    chk("seq_cmd2_wrt", 32'(wrt), 32'd1);
    step();
    chk("seq_wait2_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_wrt", 32'(wrt), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_lft", 32'(lft_ld), 32'd0);
    chk("arst_rght", 32'(rght_ld), 32'd0);
    chk("arst_batt", 32'(batt), 32'd0);
    step();
    rst = 1'b0;
    done = 1'b1; rd_data = 16'h0ABC;
    step();
    done = 1'b0;
    chk("late_done_busy", 32'(busy), 32'd0);
    chk("late_done_vld", 32'(vld_bus()), 32'd0);
    chk("late_done_lft", 32'(lft_ld), 32'd0);
    chk("late_done_wrt", 32'(wrt), 32'd0);
    nxt = 1'b1;
    step();
    nxt = 1'b0;
    chk("post_rst_wrt", 32'(wrt), 32'd1);
    chk("post_rst_cmd", 32'(cmd), 32'h0000);

    // randomized run against the protocol-level model
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptr_m = 0; act = 1'b0; pend_m = 1'b0; restart_next = 1'b0; wrt2_next = 1'b0;
    outstanding = 1'b0; frames = 0; done_at = 0; cmd_m = 16'h0000;
    for (int k = 0; k < 3; k++) reg_m[k] = 12'h000;

    for (int j = 0; j < 3000; j++) begin
      restart_now = restart_next; restart_next = 1'b0;
      wrt2_now = wrt2_next; wrt2_next = 1'b0;
      n_r = ($urandom_range(0, 7) == 0);
      rd_r = 16'($urandom);
      d_r = 1'b0; real_d = 1'b0;
      if (outstanding && j == done_at) begin
        d_r = 1'b1; real_d = 1'b1; outstanding = 1'b0;
      end else if (!outstanding && $urandom_range(0, 9) == 0) begin
        d_r = 1'b1;
      end
      exp_wrt = 1'b0; exp_vld = 3'b000;
      if (restart_now) begin
        act = 1'b1; frames = 0; exp_wrt = 1'b1;
        cmd_m = 16'(chans[ptr_m] * 2048);
      end else if (real_d) begin
        if (frames == 0) begin
          frames = 1; wrt2_next = 1'b1;
          if (n_r) pend_m = 1'b1;
        end else begin
          reg_m[ptr_m] = rd_r[11:0];
          exp_vld[ptr_m] = 1'b1;
          ptr_m = (ptr_m + 1) % 3;
          act = 1'b0;
          if (pend_m || n_r) restart_next = 1'b1;
          pend_m = 1'b0;
        end
      end else if (wrt2_now) begin
        exp_wrt = 1'b1;
        if (n_r) pend_m = 1'b1;
      end else if (n_r) begin
        if (act) begin
          pend_m = 1'b1;
        end else begin
          act = 1'b1; frames = 0; exp_wrt = 1'b1;
          cmd_m = 16'(chans[ptr_m] * 2048);
        end
      end

      nxt = n_r; done = d_r; rd_data = rd_r;
      step();
      if (exp_wrt) begin
        outstanding = 1'b1;
        done_at = j + int'($urandom_range(2, 6));
      end
      chk($sformatf("r%0d_wrt", j), 32'(wrt), 32'(exp_wrt));
      chk($sformatf("r%0d_busy", j), 32'(busy), 32'(act));
      chk($sformatf("r%0d_vld", j), 32'(vld_bus()), 32'(exp_vld));
      chk($sformatf("r%0d_lft", j), 32'(lft_ld), 32'(reg_m[0]));
      chk($sformatf("r%0d_rght", j), 32'(rght_ld), 32'(reg_m[1]));
      chk($sformatf("r%0d_batt", j), 32'(batt), 32'(reg_m[2]));
      if (exp_wrt) chk($sformatf("r%0d_cmd", j), 32'(cmd), 32'(cmd_m));
    end
    nxt = 1'b0; done = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
